// File: rtl/shreg_seq_pkg.sv
// shreg_seq_pkg: shared encodings for the shift-register sequencer.
package shreg_seq_pkg;
  typedef enum logic [1:0] {
    M_HOLD       = 2'b00,
    M_SHIFT_UP   = 2'b01,
    M_SHIFT_DOWN = 2'b10,
    M_LOAD       = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    OP_LOAD       = 2'b00,
    OP_SHIFT_UP   = 2'b01,
    OP_SHIFT_DOWN = 2'b10,
    OP_ROTATE_UP  = 2'b11
  } op_e;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  localparam logic [3:0] MAX_SHIFT = 4'd8;
endpackage

// File: rtl/shreg_seq_cnt.sv
// shreg_seq_cnt: clamped shift counter that saturates at zero.
module shreg_seq_cnt
  import shreg_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] cnt_in,
  output logic [3:0] cnt,
  output logic       zero
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= cnt_in > MAX_SHIFT ? MAX_SHIFT : cnt_in;
    else if (dec && !zero) cnt <= cnt - 4'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/shreg_seq.sv
// shreg_seq: command sequencer driving an external 8-bit shift register via Q feedback.
// Define SHREG_SEQ_ROTATE_EN to make op 11 rotate (LSD=Q[7]) instead of acting as op 01.
module shreg_seq
  import shreg_seq_pkg::*;
(
  input  logic       clk,
  input  logic       CLR,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_cnt,
  input  logic       ser_in,
  input  logic [7:0] Q,
  output logic       S1,
  output logic       S0,
  output logic [7:0] D,
  output logic       LSD,
  output logic       RSD,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       done
);
  state_e     state, state_nxt;
  mode_e      mode;
  op_e        op;
  logic [7:0] data;
  logic [3:0] cnt;
  logic       pend, zero, accept, rot, down, unused_q;
  // The accepted command waits one cycle in IDLE (pend) so the first update lands at edge k+2.
  assign cmd_ready = state == IDLE && !pend && !CLR;
  assign accept = cmd_valid && cmd_ready;
  assign down = op == OP_SHIFT_DOWN;
  assign unused_q = ^Q[6:1];
  assign {S1, S0} = mode;
`ifdef SHREG_SEQ_ROTATE_EN
  assign rot = op == OP_ROTATE_UP;
`else
  assign rot = 1'b0;
`endif
  shreg_seq_cnt u_cnt (
    .clk    (clk),
    .rst    (CLR),
    .load   (accept),
    .dec    (state == SHIFT),
    .cnt_in (cmd_cnt),
    .cnt    (cnt),
    .zero   (zero)
  );
  always_ff @(posedge clk or posedge CLR)
    if (CLR) begin
      state <= IDLE;
      pend  <= 1'b0;
      op    <= OP_LOAD;
      data  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= accept;
      if (accept) begin
        op   <= op_e'(cmd_op);
        data <= cmd_data;
      end
    end
  always_comb begin
    state_nxt = state;
    mode      = M_HOLD;
    D         = '0;
    LSD       = 1'b0;
    RSD       = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (pend) state_nxt = op == OP_LOAD ? LOAD : zero ? DONE : SHIFT;
      LOAD: begin
        mode      = M_LOAD;
        D         = data;
        state_nxt = DONE;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        mode      = down ? M_SHIFT_DOWN : M_SHIFT_UP;
        LSD       = down ? 1'b0 : rot ? Q[7] : ser_in;
        RSD       = down ? ser_in : 1'b0;
        ser_out   = down ? Q[0] : Q[7];
        state_nxt = cnt == 4'd1 ? DONE : SHIFT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_shreg_seq.sv
// tb_shreg_seq: vector table, random commands against an arithmetic model, reset/back-to-back sequences.
module tb_shreg_seq;
  logic       clk = 1'b0;
  logic       CLR = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic [3:0] cmd_cnt = '0;
  logic       ser_in = 1'b0;
  logic [7:0] q;
  logic       S1, S0, LSD, RSD, ser_out, ser_valid, done;
  logic [7:0] D;
  logic       pre_en = 1'b0;
  logic [7:0] pre_val = '0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [3:0] cnt;
    logic [7:0] q0;
    logic [7:0] fill;
    logic [7:0] exp_q;
    int         exp_n;
    logic [7:0] exp_outs;
    int         exp_done;
  } vec_t;
  vec_t vt[7];

  shreg_seq dut (
    .clk(clk), .CLR(CLR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .ser_in(ser_in),
    .Q(q), .S1(S1), .S0(S0), .D(D), .LSD(LSD), .RSD(RSD),
    .ser_out(ser_out), .ser_valid(ser_valid), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream register; it has no connection to CLR.
  always @(posedge clk)
    if (pre_en) q <= pre_val;
    else case ({S1, S0})
      2'b01: q <= {q[6:0], LSD};
      2'b10: q <= {RSD, q[7:1]};
      2'b11: q <= D;
      default: ;
    endcase

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // fill[i] is the serial bit offered during the i-th shift; eo[i] is the i-th bit leaving.
  function automatic void model(input logic [1:0] op, input logic [7:0] data, input logic [7:0] q0,
                                input logic [7:0] fill, input logic [3:0] cnt,
                                output logic [7:0] eq, output int n, output logic [7:0] eo, output int dc);
    logic [15:0] full;
    bit rot_en = 0;
`ifdef SHREG_SEQ_ROTATE_EN
    rot_en = 1;
`endif
    n  = op == 2'd0 ? 0 : (cnt > 4'd8 ? 8 : int'(cnt));
    dc = op == 2'd0 ? 3 : n + 2;
    eo = '0;
    if (op == 2'd0) eq = data;
    else if (op == 2'd3 && rot_en) begin
      full = {q0, q0} << n;
      eq = full[15:8];
      for (int i = 0; i < n; i++) eo[i] = q0[7-i];
    end else if (op == 2'd2) begin
      full = {8'h00, q0};
      for (int i = 0; i < n; i++) full[8+i] = fill[i];
      eq = 8'(full >> n);
      for (int i = 0; i < n; i++) eo[i] = full[i];
    end else begin
      full = {8'h00, q0} << n;
      for (int i = 0; i < n; i++) full[n-1-i] = fill[i];
      eq = full[7:0];
      for (int i = 0; i < n; i++) eo[i] = full[7+n-i];
    end
  endfunction

  task automatic run(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                     input logic [7:0] q0, input logic [7:0] fill,
                     output logic [7:0] got_q, output int nvalid, output logic [7:0] outs, output int done_c);
    @(negedge clk);
    pre_en = 1'b1; pre_val = q0; cmd_valid = 1'b0;
    @(negedge clk);
    pre_en = 1'b0;
    #1 chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt;
    nvalid = 0; outs = '0; done_c = 0;
    for (int c = 1; c <= 14 && done_c == 0; c++) begin
      @(negedge clk);
      cmd_op = 2'($urandom); cmd_data = 8'($urandom); cmd_cnt = 4'($urandom);
      ser_in = (c >= 2 && c <= 9) ? fill[c-2] : 1'($urandom);
      #1;
      if (c == 1) chk("pending_not_ready", cmd_ready, 0);
      if (op == 2'd0 && c == 2) begin
        chk("load_mode", {S1, S0}, 3);
        chk("load_data", D, data);
      end
      if (ser_valid) begin
        if (nvalid < 8) outs[nvalid] = ser_out;
        nvalid++;
      end
      if (done) begin
        done_c = c;
        cmd_valid = 1'b0;
        chk("done_mode", {S1, S0}, 0);
      end
    end
    cmd_valid = 1'b0;
    got_q = q;
    @(negedge clk);
    #1 chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] gq, go, eq, eo;
    logic [1:0] rop;
    logic [3:0] rcnt;
    logic [7:0] rdata, rq0, rfill;
    int gn, gd, en, ed;
    bit bad_flag;
    logic [6:0] e_rdy, e_done, e_load;

    vt[0] = '{2'd0, 8'hA5, 4'd0,  8'h00, 8'h00, 8'hA5, 0, 8'h00, 3};
    vt[1] = '{2'd1, 8'h00, 4'd3,  8'h81, 8'hFF, 8'h0F, 3, 8'h01, 5};
    vt[2] = '{2'd2, 8'h00, 4'd12, 8'h81, 8'h00, 8'h00, 8, 8'h81, 10};
`ifdef SHREG_SEQ_ROTATE_EN
    vt[3] = '{2'd3, 8'h00, 4'd1,  8'h81, 8'h00, 8'h03, 1, 8'h01, 3};
`else
    vt[3] = '{2'd3, 8'h00, 4'd1,  8'h81, 8'h00, 8'h02, 1, 8'h01, 3};
`endif
    vt[4] = '{2'd1, 8'h00, 4'd0,  8'h5A, 8'hFF, 8'h5A, 0, 8'h00, 2};
    vt[5] = '{2'd2, 8'h00, 4'd1,  8'h3C, 8'h01, 8'h9E, 1, 8'h00, 3};
    vt[6] = '{2'd1, 8'h00, 4'd15, 8'hFF, 8'h55, 8'hAA, 8, 8'hFF, 10};

    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_mode", {S1, S0}, 0);
    chk("rst_d", D, 0);
    chk("rst_lsd_rsd", {LSD, RSD}, 0);
    chk("rst_ser", {ser_out, ser_valid}, 0);
    chk("rst_done", done, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    CLR = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);

    foreach (vt[i]) begin
      run(vt[i].op, vt[i].data, vt[i].cnt, vt[i].q0, vt[i].fill, gq, gn, go, gd);
      chk($sformatf("vec%0d_q", i), gq, vt[i].exp_q);
      chk($sformatf("vec%0d_nvalid", i), gn, vt[i].exp_n);
      chk($sformatf("vec%0d_outs", i), go, vt[i].exp_outs);
      chk($sformatf("vec%0d_done_cycle", i), gd, vt[i].exp_done);
    end

    for (int r = 0; r < 40; r++) begin
      rop = 2'($urandom); rcnt = 4'($urandom); rdata = 8'($urandom);
      rq0 = 8'($urandom); rfill = 8'($urandom);
      model(rop, rdata, rq0, rfill, rcnt, eq, en, eo, ed);
      run(rop, rdata, rcnt, rq0, rfill, gq, gn, go, gd);
      chk($sformatf("rnd%0d_q", r), gq, eq);
      chk($sformatf("rnd%0d_nvalid", r), gn, en);
      chk($sformatf("rnd%0d_outs", r), go, eo);
      chk($sformatf("rnd%0d_done_cycle", r), gd, ed);
    end

    // Back-to-back loads with cmd_valid held high through DONE.
    e_rdy = 7'b0001000; e_done = 7'b1000100; e_load = 7'b0100010;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'h11;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) cmd_data = 8'h22;
      if (c == 5) cmd_valid = 1'b0;
      #1;
      chk($sformatf("b2b_ready_c%0d", c), cmd_ready, e_rdy[c-1]);
      chk($sformatf("b2b_done_c%0d", c), done, e_done[c-1]);
      chk($sformatf("b2b_load_c%0d", c), {S1, S0} == 2'b11, e_load[c-1]);
      if (e_load[c-1]) chk($sformatf("b2b_d_c%0d", c), D, c == 2 ? 8'h11 : 8'h22);
    end
    chk("b2b_q", q, 8'h22);

    // CLR during the 4th shift cycle of an 8-shift.
    @(negedge clk);
    pre_en = 1'b1; pre_val = 8'h81;
    @(negedge clk);
    pre_en = 1'b0; ser_in = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_cnt = 4'd8;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 5) CLR = 1'b1;
      #1;
      if (c >= 2 && c <= 4) chk($sformatf("abort_valid_c%0d", c), ser_valid, 1);
    end
    chk("abort_mode", {S1, S0}, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", ser_valid, 0);
    chk("abort_ready_in_clr", cmd_ready, 0);
    @(negedge clk);
    chk("abort_q_kept", q, 8'h0F);
    CLR = 1'b0;
    #1 chk("abort_ready_release", cmd_ready, 1);
    bad_flag = 0;
    repeat (10) begin
      @(negedge clk);
      #1 if (done || ser_valid || {S1, S0} != 2'b00) bad_flag = 1;
    end
    chk("abort_no_done", bad_flag, 0);
    chk("abort_q_final", q, 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
